// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//   Time-set controller for the digital clock. Debounces the MODE and INC keys,
//   sequences RUN -> SET_HOUR -> SET_MIN -> RUN, issues single-cycle increment
//   strobes to the hour/minute counters, gates the seconds counter while setting,
//   and produces blanking levels so the field being set blinks on the display.
//
//   Optional feature: define AUTO_REPEAT_EN to build INC auto-repeat (2 Hz after
//   HOLD_TICKS half_ticks of holding INC in a SET state).
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active-low
//   sec_tick    in   1 Hz enable, one clk wide
//   half_tick   in   2 Hz enable, one clk wide
//   btn_mode_n  in   raw MODE key, active-low, asynchronous
//   btn_inc_n   in   raw INC key, active-low, asynchronous
//   run_en      out  1 = seconds counter may count
//   inc_hour    out  one-clk strobe: hour counter +1
//   inc_min     out  one-clk strobe: minute counter +1 (no carry into hours)
//   clr_sec     out  one-clk strobe: clear seconds to 00
//   blank_hour  out  1 = blank the hour digits
//   blank_min   out  1 = blank the minute digits
//   mode        out  00 RUN, 01 SET_HOUR, 10 SET_MIN
module clock_set_ctrl #(
    parameter logic [19:0] DEB_CYCLES  = 20'd500000,
    parameter logic [5:0]  TIMEOUT_SEC = 6'd30
`ifdef AUTO_REPEAT_EN
    ,
    parameter logic [2:0]  HOLD_TICKS  = 3'd3
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       half_tick,
    input  logic       btn_mode_n,
    input  logic       btn_inc_n,
    output logic       run_en,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec,
    output logic       blank_hour,
    output logic       blank_min,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    // Key index 0 = MODE, 1 = INC
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  deb;
    logic [1:0]  deb_d;
    logic [1:0]  arm;
    logic [19:0] deb_cnt [2];

    logic mode_ev;
    logic inc_ev;
    logic rep_ev;

    state_t     state, state_n;
    logic       phase, phase_n;
    logic [5:0] tcnt, tcnt_n;
    logic       inc_hour_n, inc_min_n, clr_sec_n;

    // Synchroniser has no reset so it keeps tracking the keys during reset;
    // this lets a key held through reset be recognised as held afterwards.
    always_ff @(posedge clk) begin
        sync1 <= {btn_inc_n, btn_mode_n};
        sync2 <= sync1;
    end

    // Debounce: accept a new level after DEB_CYCLES consecutive samples that
    // differ from the current debounced level. arm only rises once a released
    // key has been seen after reset, so a key held through reset is ignored
    // until it is released and pressed again.
    always_ff @(posedge clk) begin
        if (!rst) begin
            deb   <= '1;
            deb_d <= '1;
            arm   <= '0;
            for (int unsigned k = 0; k < 2; k++) begin
                deb_cnt[k] <= '0;
            end
        end else begin
            deb_d <= deb;
            for (int unsigned k = 0; k < 2; k++) begin
                if (sync2[k] == deb[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_CYCLES - 20'd1) begin
                    deb[k]     <= sync2[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 20'd1;
                end
                if (sync2[k] && deb[k]) begin
                    arm[k] <= 1'b1;
                end
            end
        end
    end

    assign mode_ev = arm[0] & deb_d[0] & ~deb[0];
    assign inc_ev  = arm[1] & deb_d[1] & ~deb[1];

`ifdef AUTO_REPEAT_EN
    logic [2:0] hold_cnt;
    logic       inc_held;

    assign inc_held = arm[1] & ~deb[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (!inc_held || state == RUN) begin
            hold_cnt <= '0;
        end else if (half_tick && hold_cnt != HOLD_TICKS) begin
            hold_cnt <= hold_cnt + 3'd1;
        end
    end

    assign rep_ev = inc_held & (state != RUN) & half_tick & (hold_cnt == HOLD_TICKS);
`else
    assign rep_ev = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            phase    <= 1'b0;
            tcnt     <= '0;
            inc_hour <= 1'b0;
            inc_min  <= 1'b0;
            clr_sec  <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            tcnt     <= tcnt_n;
            inc_hour <= inc_hour_n;
            inc_min  <= inc_min_n;
            clr_sec  <= clr_sec_n;
        end
    end

    // Priority: MODE event > INC/repeat strobe > timeout/blink housekeeping.
    // Later assignments override earlier ones, so an INC in the same clk as
    // the final sec_tick keeps the SET state.
    always_comb begin
        state_n    = state;
        phase_n    = phase;
        tcnt_n     = tcnt;
        inc_hour_n = 1'b0;
        inc_min_n  = 1'b0;
        clr_sec_n  = 1'b0;

        if (state == RUN) begin
            phase_n = 1'b0;
            tcnt_n  = '0;
        end else begin
            if (half_tick) begin
                phase_n = ~phase;
            end
            if (sec_tick) begin
                if (tcnt == TIMEOUT_SEC - 6'd1) begin
                    state_n = RUN;
                    tcnt_n  = '0;
                    phase_n = 1'b0;
                end else begin
                    tcnt_n = tcnt + 6'd1;
                end
            end
        end

        if (mode_ev) begin
            tcnt_n  = '0;
            phase_n = 1'b0;
            case (state)
                RUN:      state_n = SET_HOUR;
                SET_HOUR: state_n = SET_MIN;
                SET_MIN: begin
                    state_n   = RUN;
                    clr_sec_n = 1'b1;
                end
                default:  state_n = RUN;
            endcase
        end else if (inc_ev || rep_ev) begin
            tcnt_n = '0;
            if (state == SET_HOUR) begin
                state_n    = SET_HOUR;
                phase_n    = 1'b0;
                inc_hour_n = 1'b1;
            end else if (state == SET_MIN) begin
                state_n   = SET_MIN;
                phase_n   = 1'b0;
                inc_min_n = 1'b1;
            end
        end
    end

    assign mode       = state;
    assign run_en     = (state == RUN);
    assign blank_hour = (state == SET_HOUR) & phase;
    assign blank_min  = (state == SET_MIN) & phase;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick;
    logic       half_tick;
    logic       btn_mode_n;
    logic       btn_inc_n;
    logic       run_en;
    logic       inc_hour;
    logic       inc_min;
    logic       clr_sec;
    logic       blank_hour;
    logic       blank_min;
    logic [1:0] mode;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected strobe codes {clr_sec, inc_min, inc_hour}, in issue order
    logic [2:0] exp_q[$];

    clock_set_ctrl #(
        .DEB_CYCLES (20'd4),
        .TIMEOUT_SEC(6'd3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sec_tick  (sec_tick),
        .half_tick (half_tick),
        .btn_mode_n(btn_mode_n),
        .btn_inc_n (btn_inc_n),
        .run_en    (run_en),
        .inc_hour  (inc_hour),
        .inc_min   (inc_min),
        .clr_sec   (clr_sec),
        .blank_hour(blank_hour),
        .blank_min (blank_min),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every strobe the DUT emits is matched against the next expected one.
    always @(negedge clk) begin
        logic [2:0] code;
        code = {clr_sec, inc_min, inc_hour};
        if (code != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {29'd0, code}, 32'd0);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                check("strobe", {29'd0, code}, {29'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_mode();
        btn_mode_n = 1'b0;
        wait_clks(12);
        btn_mode_n = 1'b1;
        wait_clks(12);
    endtask

    task automatic press_inc();
        btn_inc_n = 1'b0;
        wait_clks(12);
        btn_inc_n = 1'b1;
        wait_clks(12);
    endtask

    task automatic pulse_half();
        half_tick = 1'b1;
        tick();
        half_tick = 1'b0;
    endtask

    task automatic pulse_sec();
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
        wait_clks(3);
    endtask

    task automatic check_sb(input string tag);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        rst        = 1'b0;
        sec_tick   = 1'b0;
        half_tick  = 1'b0;
        btn_mode_n = 1'b1;
        btn_inc_n  = 1'b1;
        wait_clks(5);

        // Reset state
        check("rst_mode", mode, 2'b00);
        check("rst_run_en", run_en, 1'b1);
        check("rst_strobes", {clr_sec, inc_min, inc_hour}, 3'b000);
        check("rst_blanks", {blank_hour, blank_min}, 2'b00);

        // Idle after reset
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_clks(250);
            check("idle_mode", mode, 2'b00);
            check("idle_run_en", run_en, 1'b1);
            check("idle_blanks", {blank_hour, blank_min}, 2'b00);
        end

        // MODE bounce then clean hold -> one event only
        for (int i = 0; i < 2; i++) begin
            btn_mode_n = 1'b1; wait_clks(2);
            btn_mode_n = 1'b0; wait_clks(2);
        end
        btn_mode_n = 1'b1; wait_clks(2);
        btn_mode_n = 1'b0; wait_clks(10);
        btn_mode_n = 1'b1; wait_clks(12);
        check("bounce_mode", mode, 2'b01);
        check("bounce_run_en", run_en, 1'b0);

        // Blink of hour field
        check("blink_h0", {blank_hour, blank_min}, 2'b00);
        pulse_half();
        check("blink_h1", {blank_hour, blank_min}, 2'b10);
        pulse_half();
        check("blink_h2", {blank_hour, blank_min}, 2'b00);

        // Simultaneous MODE and INC in SET_HOUR: MODE wins, no strobe
        btn_mode_n = 1'b0;
        btn_inc_n  = 1'b0;
        wait_clks(12);
        btn_mode_n = 1'b1;
        btn_inc_n  = 1'b1;
        wait_clks(12);
        check("simul_mode", mode, 2'b10);
        check_sb("simul_sb");

        // SET_MIN: blink, then INC forces phase to 0; three strobes
        pulse_half();
        check("blink_m1", {blank_hour, blank_min}, 2'b01);
        exp_q.push_back(3'b010);
        press_inc();
        check("inc_unblank", blank_min, 1'b0);
        exp_q.push_back(3'b010);
        press_inc();
        exp_q.push_back(3'b010);
        press_inc();
        check_sb("inc_min_sb");
        check("setmin_mode", mode, 2'b10);

        // Exit SET_MIN via MODE -> clr_sec
        exp_q.push_back(3'b100);
        press_mode();
        check("exit_mode", mode, 2'b00);
        check("exit_run_en", run_en, 1'b1);
        check_sb("clr_sec_sb");

        // INC ignored in RUN
        press_inc();
        check("run_inc_mode", mode, 2'b00);
        check_sb("run_inc_sb");

        // Timeout from SET_HOUR, no clr_sec
        press_mode();
        check("to_enter", mode, 2'b01);
        pulse_sec();
        pulse_sec();
        check("to_before", mode, 2'b01);
        pulse_sec();
        check("to_after", mode, 2'b00);
        check("to_run_en", run_en, 1'b1);
        check_sb("to_sb");

        // INC event clears the timeout counter
        press_mode();
        pulse_sec();
        pulse_sec();
        exp_q.push_back(3'b001);
        press_inc();
        pulse_sec();
        pulse_sec();
        check("to_clr_hold", mode, 2'b01);
        pulse_sec();
        check("to_clr_exit", mode, 2'b00);
        check_sb("to_clr_sb");

        // Reset mid-set with both keys held through reset
        press_mode();
        check("mid_enter", mode, 2'b01);
        btn_mode_n = 1'b0;
        btn_inc_n  = 1'b0;
        wait_clks(3);
        rst = 1'b0;
        tick();
        check("mid_rst_mode", mode, 2'b00);
        check("mid_rst_strobes", {clr_sec, inc_min, inc_hour}, 3'b000);
        wait_clks(3);
        rst = 1'b1;
        wait_clks(20);
        check("held_rst_mode", mode, 2'b00);
        btn_mode_n = 1'b1;
        btn_inc_n  = 1'b1;
        wait_clks(12);
        check("held_release_mode", mode, 2'b00);
        check_sb("held_sb");
        press_mode();
        check("repress_mode", mode, 2'b01);
        press_mode();
        check("to_setmin", mode, 2'b10);

        // Held INC in SET_MIN across 8 half_ticks
        exp_q.push_back(3'b010);
`ifdef AUTO_REPEAT_EN
        for (int i = 0; i < 5; i++) exp_q.push_back(3'b010);
`endif
        btn_inc_n = 1'b0;
        wait_clks(12);
        for (int i = 0; i < 8; i++) begin
            pulse_half();
            wait_clks(5);
        end
        btn_inc_n = 1'b1;
        wait_clks(12);
        check_sb("hold_sb");
        check("hold_mode", mode, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
